msu_data_ctrl: RTL and testbench
================================

// Module: msu_data_ctrl
// PURPOSE
//  Sequences the MSU-1 data port: latches the 32-bit seek address from $2000-$2003, fetches data-file bytes
//  from the HPS/SDRAM byte port into a prefetch FIFO, and serves $2001 reads from that FIFO.
//  It drives the STATUS data_busy bit and sits beside the MSU register block on the S-CPU bus.
// PARAMETERS
//  FIFO_DEPTH  8   prefetch depth in bytes; power of two, 2..64.
//  ADDR_W      32  data-file byte address width.
// PORTS
//  CLK        in   1       system clock; the only clock.
//  RST_N      in   1       reset, asynchronous and active-low.
//  ENABLE     in   1       bus access strobe.
//  RD_N       in   1       bus read, active-low.
//  WR_N       in   1       bus write, active-low.
//  ADDR       in   24      S-CPU address.
//  DIN        in   8       bus write data.
//  rd_data    out  8       byte for $2001; valid while a $2001 read is decoded.
//  data_busy  out  1       STATUS bit 7.
//  mem_req    out  1       fetch request; held high until mem_ack.
//  mem_addr   out  ADDR_W  fetch byte address; stable while mem_req=1.
//  mem_ack    in   1       one-cycle pulse; mem_data is valid in the same cycle.
//  mem_data   in   8       fetched byte.
// BEHAVIOUR
//  Decode
//  - Bus access requires ENABLE and bank $00-$3F or $80-$BF.
//  - Access = rising edge of (decoded & ~WR_N) or (decoded & ~RD_N); one event per bus cycle, however many CLKs it spans.
//  Seek latch
//  - Write events to $2000..$2003 load seek[7:0], [15:8], [23:16], [31:24].
//  - The $2003 write commits the seek with its new byte.
//  Reset values
//  - rd_data=0, data_busy=0, mem_req=0, mem_addr=0; seek latch=0; FIFO empty; state IDLE.
//  FSM (package enum)
//  - IDLE:  no fetch. Commit -> FILL.
//  - FILL:  commit flushes the FIFO and loads fetch_ptr=seek; data_busy=1 from the cycle after commit.
//           Fetch until count==FIFO_DEPTH, then clear data_busy and go to RUN.
//  - RUN:   refill whenever count<FIFO_DEPTH and no fetch is outstanding. Commit -> FILL, or -> ABORT if mem_req=1.
//  - ABORT: a commit arrived with a fetch outstanding. mem_req stays high until mem_ack; that byte is discarded.
//           Next cycle -> FILL from the new seek. data_busy=1 throughout.
//  - A commit in FILL behaves the same: ABORT if a fetch is outstanding, otherwise restart FILL directly.
//  - Last commit wins.
//  Fetch handshake
//  - mem_req rises with mem_addr=fetch_ptr.
//  - On mem_ack: push mem_data (unless ABORT), fetch_ptr += 1 modulo 2^ADDR_W, mem_req low for >=1 cycle.
//  - At most one fetch is outstanding.
//  $2001 read event
//  - data_busy=1: rd_data=0, no pop.
//  - FIFO empty: rd_data=0, no pop; an underrun, not an error.
//  - Otherwise: rd_data=head, pop. rd_data holds until the next $2001 event.
//  - Pop and push in the same cycle: count unchanged, order preserved.
//  Reset mid-operation
//  - mem_req drops asynchronously and the FIFO empties.
//  - The mem side must tolerate a late mem_ack, which is ignored in IDLE.
// STRUCTURE
//  - msu_pkg: register addresses MSU_SEEK0..3=$2000..$2003 and MSU_READ=$2001, the bank-decode function,
//    and the FSM enum {IDLE, FILL, RUN, ABORT}.
//  - Sub-module msu_prefetch_fifo: synchronous FIFO, DEPTH param, push/pop/flush, count/full/empty.
//  - Top level: decode, edge detect, seek latch, FSM, fetch pointer.
// TESTING
//  1. Write $00,$12,$34,$00 to $2000-$2003.
//     -> data_busy=1; mem_addr sequence 0x00341200..0x00341207; data_busy=0 after the 8th ack;
//        eight $2001 reads return the bytes in order.
//  2. After test 1, read $2001 8 more times with a 3-cycle ack memory.
//     -> mem_addr continues 0x00341208 onward; bytes continuous; no 0x00 unless the FIFO is empty.
//  3. Commit seek 0x100, then commit 0x200 while mem_req=1 for 0x100.
//     -> ABORT; the 0x100 byte is discarded; first pushed byte is from 0x200.
//  4. $2001 reads while data_busy=1.
//     -> rd_data=0x00 and the FIFO count is unchanged.
//  5. Hold RD_N low on $2001 for 6 CLKs, and access bank $40.
//     -> exactly one pop; the bank-$40 access has no effect.
//  6. Assert RST_N low mid-FILL with mem_req=1.
//     -> all outputs go to reset values immediately; a later stray mem_ack causes no push.

Source files
------------

// File: rtl/msu_pkg.sv
// Shared definitions for the MSU-1 data port: register map, bank decode and
// the data-port sequencer states.
package msu_pkg;

    localparam logic [15:0] MSU_SEEK0 = 16'h2000;
    localparam logic [15:0] MSU_SEEK1 = 16'h2001;
    localparam logic [15:0] MSU_SEEK2 = 16'h2002;
    localparam logic [15:0] MSU_SEEK3 = 16'h2003;
    localparam logic [15:0] MSU_READ  = 16'h2001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        ABORT = 2'd3
    } msu_state_e;

    // System-area banks $00-$3F and $80-$BF are exactly those with bit 6 clear.
    function automatic logic bank_ok(input logic [7:0] bank);
        return ~bank[6];
    endfunction

endpackage

// File: rtl/msu_prefetch_fifo.sv
// Byte-wide synchronous prefetch FIFO with flush. The head byte is presented
// combinationally on dout; push while full is accepted only alongside a pop.
module msu_prefetch_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/msu_data_ctrl.sv
// MSU-1 data port sequencer: seek latch on $2000-$2003, prefetch of data-file
// bytes over the mem_req/mem_ack port, and $2001 reads served from the FIFO.
module msu_data_ctrl
    import msu_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ENABLE,
    input  logic              RD_N,
    input  logic              WR_N,
    input  logic [23:0]       ADDR,
    input  logic [7:0]        DIN,
    output logic [7:0]        rd_data,
    output logic              data_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    msu_state_e        state, state_n;
    logic [31:0]       seek;
    logic [31:0]       commit_seek;
    logic [ADDR_W-1:0] fetch_ptr;

    logic decoded, wr_lvl, rd_lvl, wr_q, rd_q;
    logic wr_ev, rd_ev, commit, ack;

    logic          push, pop, flush;
    logic [7:0]    head;
    logic [CW-1:0] count;
    logic          full, empty;

    logic load_ptr, inc_ptr, req_set, req_clr, busy_set, busy_clr;

    // One event per bus cycle: only the leading edge of a strobe counts.
    assign decoded     = ENABLE && bank_ok(ADDR[23:16]);
    assign wr_lvl      = decoded && !WR_N;
    assign rd_lvl      = decoded && !RD_N;
    assign wr_ev       = wr_lvl && !wr_q;
    assign rd_ev       = rd_lvl && !rd_q && (ADDR[15:0] == MSU_READ);
    assign commit      = wr_ev && (ADDR[15:0] == MSU_SEEK3);
    assign commit_seek = {DIN, seek[23:0]};
    assign ack         = mem_req && mem_ack;

    assign pop = rd_ev && !data_busy && !empty && !flush;

    msu_prefetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .flush (flush),
        .push  (push),
        .din   (mem_data),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        push     = 1'b0;
        flush    = 1'b0;
        load_ptr = 1'b0;
        inc_ptr  = 1'b0;
        req_set  = 1'b0;
        req_clr  = 1'b0;
        busy_set = 1'b0;
        busy_clr = 1'b0;
        case (state)
            FILL, RUN: begin
                if (ack) begin
                    push    = 1'b1;
                    inc_ptr = 1'b1;
                    req_clr = 1'b1;
                end
                // mem_req is registered, so a just-acked fetch stays low a cycle.
                if (!mem_req && !full) req_set = 1'b1;
                if (state == FILL && count == CW'(FIFO_DEPTH)) begin
                    busy_clr = 1'b1;
                    state_n  = RUN;
                end
            end
            ABORT: begin
                if (ack) begin
                    req_clr = 1'b1;
                    state_n = FILL;
                end
            end
            default: ;
        endcase
        // A commit overrides everything; the in-flight byte, if any, is dropped.
        if (commit) begin
            flush    = 1'b1;
            push     = 1'b0;
            load_ptr = 1'b1;
            inc_ptr  = 1'b0;
            req_set  = 1'b0;
            busy_set = 1'b1;
            busy_clr = 1'b0;
            state_n  = (mem_req && !mem_ack) ? ABORT : FILL;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            seek      <= '0;
            fetch_ptr <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            data_busy <= 1'b0;
            rd_data   <= '0;
        end else begin
            wr_q <= wr_lvl;
            rd_q <= rd_lvl;

            if (wr_ev) begin
                case (ADDR[15:0])
                    MSU_SEEK0: seek[7:0]   <= DIN;
                    MSU_SEEK1: seek[15:8]  <= DIN;
                    MSU_SEEK2: seek[23:16] <= DIN;
                    MSU_SEEK3: seek[31:24] <= DIN;
                    default:   ;
                endcase
            end

            if (load_ptr)     fetch_ptr <= ADDR_W'(commit_seek);
            else if (inc_ptr) fetch_ptr <= fetch_ptr + ADDR_W'(1);

            if (req_set) begin
                mem_req  <= 1'b1;
                mem_addr <= fetch_ptr;
            end else if (req_clr) begin
                mem_req  <= 1'b0;
            end

            if (busy_set)      data_busy <= 1'b1;
            else if (busy_clr) data_busy <= 1'b0;

            if (rd_ev) rd_data <= pop ? head : 8'h00;
        end
    end

endmodule

// File: tb/tb_msu_data_ctrl.sv
// Directed scoreboard bench for msu_data_ctrl with a behavioural byte memory
// whose contents are a fixed function of the byte address.
module tb_msu_data_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        ENABLE = 1'b0;
    logic        RD_N = 1'b1;
    logic        WR_N = 1'b1;
    logic [23:0] ADDR = '0;
    logic [7:0]  DIN = '0;
    logic [7:0]  rd_data;
    logic        data_busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = '0;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_q [$];
    logic [31:0] exp_addr = '0;
    int          lat = 1;
    bit          mem_en = 1'b0;
    int          man_cnt = 0;
    int          man_done = 0;
    logic [7:0]  man_data = '0;

    msu_data_ctrl #(.FIFO_DEPTH(8), .ADDR_W(32)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ENABLE    (ENABLE),
        .RD_N      (RD_N),
        .WR_N      (WR_N),
        .ADDR      (ADDR),
        .DIN       (DIN),
        .rd_data   (rd_data),
        .data_busy (data_busy),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] fbyte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Memory model: latency-lat responder, or a one-shot manual ack.
    initial begin : responder
        int wcnt;
        wcnt = 0;
        forever begin
            @(negedge CLK);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (man_done != man_cnt) begin
                mem_data = man_data;
                mem_ack  = 1'b1;
                man_done = man_cnt;
            end else if (mem_en && mem_req) begin
                wcnt++;
                if (wcnt >= lat) begin
                    check("mem_addr", mem_addr, exp_addr);
                    exp_addr++;
                    mem_data = fbyte(mem_addr);
                    mem_ack  = 1'b1;
                    wcnt     = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic bus_write(input logic [23:0] a, input logic [7:0] d);
        @(negedge CLK);
        ADDR = a; DIN = d; ENABLE = 1'b1; WR_N = 1'b0;
        @(negedge CLK);
        WR_N = 1'b1; ENABLE = 1'b0;
    endtask

    task automatic seek_to(input logic [31:0] s);
        for (int i = 0; i < 4; i++)
            bus_write(24'h002000 + 24'(i), s[8*i +: 8]);
    endtask

    task automatic bus_read(input logic [23:0] a, input int cyc);
        @(negedge CLK);
        ADDR = a; ENABLE = 1'b1; RD_N = 1'b0;
        repeat (cyc) @(negedge CLK);
        RD_N = 1'b1; ENABLE = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(fbyte(base + 32'(i)));
    endtask

    task automatic read_pop(input string tag, input logic [23:0] a, input int cyc);
        logic [7:0] e;
        bus_read(a, cyc);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        check(tag, rd_data, e);
    endtask

    task automatic wait_busy_clear(input string tag);
        int n;
        n = 0;
        while (data_busy !== 1'b0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check(tag, data_busy, 1'b0);
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check(tag, mem_req, 1'b1);
    endtask

    task automatic man_ack(input logic [7:0] d);
        man_data = d;
        man_cnt++;
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_busy", data_busy, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // 1: seek 0x00341200, fill, drain eight bytes
        exp_addr = 32'h0034_1200;
        lat = 1;
        mem_en = 1'b1;
        seek_to(32'h0034_1200);
        check("busy_after_commit", data_busy, 1'b1);
        wait_busy_clear("fill1_done");
        check("fill1_fetch_count", exp_addr, 32'h0034_1208);
        push_exp(32'h0034_1200, 8);
        for (int i = 0; i < 8; i++) read_pop("t1_read", 24'h002001, 1);

        // 2: continue with slower memory
        repeat (60) @(negedge CLK);
        lat = 3;
        push_exp(32'h0034_1208, 8);
        for (int i = 0; i < 8; i++) read_pop("t2_read", 24'h002001, 1);
        repeat (100) @(negedge CLK);
        check("idle_when_full", mem_req, 1'b0);
        check("refill_addr", exp_addr, 32'h0034_1218);
        mem_en = 1'b0;

        // 3: re-seek while a fetch is outstanding
        seek_to(32'h0000_0100);
        wait_req("req_0x100");
        check("req_addr_0x100", mem_addr, 32'h0000_0100);
        seek_to(32'h0000_0200);
        check("abort_req_held", mem_req, 1'b1);
        check("abort_addr_held", mem_addr, 32'h0000_0100);
        check("abort_busy", data_busy, 1'b1);

        // 4: reads while busy return zero and do not pop
        bus_read(24'h002001, 1);
        check("busy_read0", rd_data, 8'h00);
        bus_read(24'h002001, 1);
        check("busy_read1", rd_data, 8'h00);
        man_ack(8'hEE);
        repeat (2) @(negedge CLK);
        check("refetch_req", mem_req, 1'b1);
        check("refetch_addr", mem_addr, 32'h0000_0200);
        exp_addr = 32'h0000_0200;
        mem_en = 1'b1;
        wait_busy_clear("fill2_done");
        push_exp(32'h0000_0200, 8);
        read_pop("first_after_abort", 24'h002001, 1);

        // 5: long strobe pops once; bank $40 is not decoded; bank $80 is
        read_pop("long_read", 24'h002001, 6);
        bus_read(24'h402001, 1);
        check("bank40_read_hold", rd_data, fbyte(32'h0000_0201));
        bus_write(24'h402003, 8'h77);
        repeat (2) @(negedge CLK);
        check("bank40_no_commit", data_busy, 1'b0);
        read_pop("after_bank40", 24'h002001, 1);
        read_pop("bank80_read", 24'h802001, 1);

        // underrun: drain a full FIFO with memory stalled
        repeat (60) @(negedge CLK);
        check("full_before_drain", mem_req, 1'b0);
        mem_en = 1'b0;
        push_exp(32'h0000_0208, 4);
        for (int i = 0; i < 8; i++) read_pop("drain_read", 24'h002001, 1);
        bus_read(24'h002001, 1);
        check("underrun_zero", rd_data, 8'h00);

        // 6: reset during FILL with a fetch outstanding
        seek_to(32'h0000_0300);
        check("t6_busy", data_busy, 1'b1);
        man_ack(8'h11);
        repeat (2) @(negedge CLK);
        check("t6_fill_req", mem_req, 1'b1);
        check("t6_fill_addr", mem_addr, 32'h0000_0300);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("async_rst_req", mem_req, 1'b0);
        check("async_rst_busy", data_busy, 1'b0);
        check("async_rst_addr", mem_addr, 32'h0);
        check("async_rst_rd", rd_data, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        man_ack(8'h55);
        repeat (3) @(negedge CLK);
        check("stray_ack_req", mem_req, 1'b0);
        check("stray_ack_busy", data_busy, 1'b0);
        bus_read(24'h002001, 1);
        check("stray_ack_no_push", rd_data, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
